// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the receive frame scheduler.
package rx_frame_pkg;

   typedef enum logic [2:0] {
      ST_GAP,
      ST_IDLE,
      ST_RECV,
      ST_DROP,
      ST_DONE
   } state_t;

   // Header field positions relative to the segment MSB byte.
   localparam int unsigned SEG_LSB_REL = 1;
   localparam int unsigned ID_REL      = 2;
   localparam int unsigned AUX_REL     = 5;
   localparam int unsigned HDR_EXTRA   = 6;

   localparam int unsigned FLAG_SEQ_ERR = 0;
   localparam int unsigned FLAG_TRUNC   = 1;

   typedef struct packed {
      logic [15:0] len;
      logic [15:0] seg;
      logic [7:0]  id;
      logic [7:0]  aux;
      logic        trunc;
      logic        seq_err;
   } meta_t;

   function automatic int unsigned hdr_len(input int unsigned seg_offset);
      return seg_offset + HDR_EXTRA;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : 16'(v + 16'd1);
   endfunction

endpackage

// File: rtl/rx_frame_sched_seq.sv
// Per-id segment continuity tracker; err_c is valid in the cycle upd is asserted.
module rx_seq_check
   import rx_frame_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        upd,
   input  logic [15:0] seg,
   input  logic [7:0]  id,
   output logic        err_c
);

   logic [15:0] last_seg;
   logic [7:0]  last_id;
   logic        seq_vld;

   assign err_c = seq_vld && (id == last_id) && (seg != 16'(last_seg + 16'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         last_seg <= 16'd0;
         last_id  <= 8'd0;
         seq_vld  <= 1'b0;
      end else if (upd) begin
         last_seg <= seg;
         last_id  <= id;
         seq_vld  <= 1'b1;
      end
   end

endmodule

// File: rtl/rx_frame_sched.sv
// Receive frame scheduler: delimits frames, writes them into a free bank of a
// two-bank RAM and hands committed banks to the consumer.
module rx_frame_sched
   import rx_frame_pkg::*;
#(
   parameter int unsigned SEG_OFFSET = 5,
   parameter int unsigned BUF_AW     = 11
) (
   input  logic              rx_clk,
   input  logic              rst,
   input  logic [7:0]        rawdata,
   input  logic              raw_en,
   output logic              buf_we,
   output logic [BUF_AW:0]   buf_waddr,
   output logic [7:0]        buf_wdata,
   output logic              out_valid,
   input  logic              out_ack,
   output logic              out_bank,
   output logic [15:0]       out_len,
   output logic [15:0]       out_seg,
   output logic [7:0]        out_id,
   output logic [7:0]        out_aux,
   output logic [1:0]        out_flags,
   output logic [15:0]       ovf_cnt,
   output logic [15:0]       runt_cnt,
   output logic [15:0]       seqerr_cnt
);

   localparam int unsigned HDR_LEN   = hdr_len(SEG_OFFSET);
   localparam logic [15:0] HDR_LEN_W = 16'(HDR_LEN);
   localparam logic [16:0] BANK_LIM  = 17'(1 << BUF_AW);
   localparam logic [15:0] IDX_SEG_HI = 16'(SEG_OFFSET);
   localparam logic [15:0] IDX_SEG_LO = 16'(SEG_OFFSET + SEG_LSB_REL);
   localparam logic [15:0] IDX_ID     = 16'(SEG_OFFSET + ID_REL);
   localparam logic [15:0] IDX_AUX    = 16'(SEG_OFFSET + AUX_REL);

   state_t      state, state_nx;
   logic        wr_bank, rd_bank, drop_frm;
   logic [1:0]  full, full_nx;
   meta_t       meta [2];
   logic [15:0] len, byte_idx, p_seg;
   logic [7:0]  p_id, p_aux;
   logic        p_trunc, in_range, seq_err_c, ack_c;
   logic        wr_en_c, take_c, start_c, runt_c, seq_upd_c, commit_c;

   assign byte_idx = (state == ST_IDLE) ? 16'd0 : len;
   assign in_range = {1'b0, len} < BANK_LIM;
   assign ack_c    = out_ack && full[rd_bank];

   always_ff @(posedge rx_clk) begin
      if (rst) state <= ST_GAP;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      wr_en_c   = 1'b0;
      take_c    = 1'b0;
      start_c   = 1'b0;
      runt_c    = 1'b0;
      seq_upd_c = 1'b0;
      commit_c  = 1'b0;
      unique case (state)
         ST_GAP:  if (!raw_en) state_nx = ST_IDLE;
         ST_IDLE: if (raw_en) begin
            take_c   = 1'b1;
            start_c  = 1'b1;
            wr_en_c  = !full[wr_bank];
            state_nx = full[wr_bank] ? ST_DROP : ST_RECV;
         end
         ST_RECV: if (raw_en) begin
            take_c  = 1'b1;
            wr_en_c = in_range;
         end else begin
            state_nx = ST_DONE;
         end
         ST_DROP: if (raw_en) take_c = 1'b1;
                  else        state_nx = ST_DONE;
         ST_DONE: begin
            state_nx  = ST_IDLE;
            runt_c    = len < HDR_LEN_W;
            seq_upd_c = !runt_c;
            commit_c  = !runt_c && !drop_frm;
         end
         default: state_nx = ST_GAP;
      endcase
   end

   // Commit and ack always target different banks, so both may apply.
   always_comb begin
      full_nx = full;
      if (commit_c) full_nx[wr_bank] = 1'b1;
      if (ack_c)    full_nx[rd_bank] = 1'b0;
   end

   rx_seq_check u_seq (
      .clk   (rx_clk),
      .rst   (rst),
      .upd   (seq_upd_c),
      .seg   (p_seg),
      .id    (p_id),
      .err_c (seq_err_c)
   );

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         buf_we     <= 1'b0;
         buf_waddr  <= '0;
         buf_wdata  <= 8'd0;
         len        <= 16'd0;
         p_seg      <= 16'd0;
         p_id       <= 8'd0;
         p_aux      <= 8'd0;
         p_trunc    <= 1'b0;
         drop_frm   <= 1'b0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         full       <= 2'b00;
         meta[0]    <= '0;
         meta[1]    <= '0;
         ovf_cnt    <= 16'd0;
         runt_cnt   <= 16'd0;
         seqerr_cnt <= 16'd0;
      end else begin
         buf_we <= wr_en_c;
         if (wr_en_c) begin
            buf_waddr <= {wr_bank, byte_idx[BUF_AW-1:0]};
            buf_wdata <= rawdata;
         end
         if (take_c) len <= start_c ? 16'd1 : sat_inc(len);
         if (start_c) begin
            drop_frm <= full[wr_bank];
            p_trunc  <= 1'b0;
         end
         if (take_c && state == ST_RECV && !in_range) p_trunc <= 1'b1;
         if (take_c) begin
            if (byte_idx == IDX_SEG_HI) p_seg[15:8] <= rawdata;
            if (byte_idx == IDX_SEG_LO) p_seg[7:0]  <= rawdata;
            if (byte_idx == IDX_ID)     p_id        <= rawdata;
            if (byte_idx == IDX_AUX)    p_aux       <= rawdata;
         end
         if (runt_c)                  runt_cnt   <= sat_inc(runt_cnt);
         if (seq_upd_c && seq_err_c)  seqerr_cnt <= sat_inc(seqerr_cnt);
         if (seq_upd_c && drop_frm)   ovf_cnt    <= sat_inc(ovf_cnt);
         if (commit_c) begin
            meta[wr_bank] <= '{len: len, seg: p_seg, id: p_id, aux: p_aux,
                               trunc: p_trunc, seq_err: seq_err_c};
            wr_bank <= ~wr_bank;
         end
         if (ack_c) rd_bank <= ~rd_bank;
         full <= full_nx;
      end
   end

   assign out_valid = full[rd_bank];
   assign out_bank  = rd_bank;
   assign out_len   = meta[rd_bank].len;
   assign out_seg   = meta[rd_bank].seg;
   assign out_id    = meta[rd_bank].id;
   assign out_aux   = meta[rd_bank].aux;
   assign out_flags[FLAG_TRUNC]   = meta[rd_bank].trunc;
   assign out_flags[FLAG_SEQ_ERR] = meta[rd_bank].seq_err;

endmodule

// File: tb/tb_rx_frame_sched.sv
// Self-checking bench for rx_frame_sched: directed table, corner sequences and
// a randomized run against a frame-level reference model.
module tb_rx_frame_sched;

   localparam int SO = 5;
   localparam int HL = SO + 6;

   logic        rx_clk = 1'b0;
   logic        rst, raw_en, out_ack, ack2;
   logic [7:0]  rawdata;
   logic        buf_we, out_valid, out_bank;
   logic [11:0] buf_waddr;
   logic [7:0]  buf_wdata, out_id, out_aux;
   logic [15:0] out_len, out_seg, ovf_cnt, runt_cnt, seqerr_cnt;
   logic [1:0]  out_flags;
   logic        we2, valid2, bank2;
   logic [5:0]  waddr2;
   logic [7:0]  wdata2, id2, aux2;
   logic [15:0] len2, seg2, ovf2, runt2, se2;
   logic [1:0]  flags2;

   always #5 rx_clk = ~rx_clk;

   rx_frame_sched dut (
      .rx_clk(rx_clk), .rst(rst), .rawdata(rawdata), .raw_en(raw_en),
      .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .out_valid(out_valid), .out_ack(out_ack), .out_bank(out_bank),
      .out_len(out_len), .out_seg(out_seg), .out_id(out_id), .out_aux(out_aux),
      .out_flags(out_flags), .ovf_cnt(ovf_cnt), .runt_cnt(runt_cnt),
      .seqerr_cnt(seqerr_cnt)
   );

   rx_frame_sched #(.SEG_OFFSET(5), .BUF_AW(5)) dut2 (
      .rx_clk(rx_clk), .rst(rst), .rawdata(rawdata), .raw_en(raw_en),
      .buf_we(we2), .buf_waddr(waddr2), .buf_wdata(wdata2),
      .out_valid(valid2), .out_ack(ack2), .out_bank(bank2),
      .out_len(len2), .out_seg(seg2), .out_id(id2), .out_aux(aux2),
      .out_flags(flags2), .ovf_cnt(ovf2), .runt_cnt(runt2), .seqerr_cnt(se2)
   );

   int checks = 0;
   int errors = 0;

   logic [11:0] wq_a[$];
   logic [7:0]  wq_d[$];
   int          cnt2, max2;

   always @(negedge rx_clk) begin
      if (buf_we === 1'b1) begin
         wq_a.push_back(buf_waddr);
         wq_d.push_back(buf_wdata);
      end
      if (we2 === 1'b1) begin
         cnt2 = cnt2 + 1;
         if (int'(waddr2) > max2) max2 = int'(waddr2);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_byte(input int i, input int len, input logic [15:0] seg,
                                             input logic [7:0] id, input logic [7:0] aux);
      if (i == SO)     return seg[15:8];
      if (i == SO + 1) return seg[7:0];
      if (i == SO + 2) return id;
      if (i == SO + 5) return aux;
      return 8'(i * 13 + len);
   endfunction

   // Called at a falling edge; returns at the falling edge after the commit edge.
   task automatic run_frame(input int len, input logic [15:0] seg, input logic [7:0] id,
                            input logic [7:0] aux, input bit ack_commit, output bit early_valid);
      wq_a.delete();
      wq_d.delete();
      for (int i = 0; i < len; i++) begin
         raw_en  = 1'b1;
         rawdata = frame_byte(i, len, seg, id, aux);
         @(negedge rx_clk);
      end
      raw_en  = 1'b0;
      rawdata = 8'd0;
      @(negedge rx_clk);
      early_valid = out_valid;
      out_ack = ack_commit;
      @(negedge rx_clk);
      out_ack = 1'b0;
   endtask

   task automatic check_writes(input int len, input bit bank, input int n_exp, input logic [15:0] seg,
                               input logic [7:0] id, input logic [7:0] aux);
      int nbad = 0;
      chk("wr_count", wq_a.size(), n_exp);
      for (int i = 0; i < n_exp && i < wq_a.size(); i++)
         if (wq_a[i] !== {bank, 11'(i)} || wq_d[i] !== frame_byte(i, len, seg, id, aux)) nbad++;
      chk("wr_content", nbad, 0);
   endtask

   task automatic ack_pulse();
      out_ack = 1'b1;
      @(negedge rx_clk);
      out_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; raw_en = 1'b0; rawdata = 8'd0; out_ack = 1'b0;
      repeat (3) @(negedge rx_clk);
      rst = 1'b0;
      @(negedge rx_clk);
   endtask

   task automatic check_reset_state();
      chk("rst_buf_we", buf_we, 0);
      chk("rst_buf_waddr", buf_waddr, 0);
      chk("rst_buf_wdata", buf_wdata, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bank", out_bank, 0);
      chk("rst_meta", {out_len, out_seg}, 0);
      chk("rst_id_aux_flags", {out_id, out_aux, out_flags}, 0);
      chk("rst_ovf", ovf_cnt, 0);
      chk("rst_runt", runt_cnt, 0);
      chk("rst_seqerr", seqerr_cnt, 0);
   endtask

   typedef struct {
      int          len;
      logic [15:0] seg;
      logic [7:0]  id, aux;
      bit          ack;
      bit          e_valid, e_bank;
      logic [15:0] e_len, e_seg;
      logic [7:0]  e_id, e_aux;
      logic [1:0]  e_flags;
      logic [15:0] e_ovf, e_runt, e_se;
   } vec_t;

   vec_t vt[10];

   bit          m_full[2];
   bit          m_wr, m_rd, m_vld;
   logic [15:0] m_last_seg, m_ovf, m_runt, m_se;
   logic [7:0]  m_last_id;
   logic [15:0] mm_len[2], mm_seg[2];
   logic [7:0]  mm_id[2], mm_aux[2];
   logic [1:0]  mm_fl[2];

   initial begin
      bit ev;
      int rl;
      logic [15:0] rs;
      logic [7:0]  rid, rav;
      bit wf, wb, rerr;

      // len seg id aux ack | valid bank len seg id aux flags | ovf runt seqerr
      vt[0] = '{50, 16'd2,      8'd1, 8'd3,    1'b0, 1'b1, 1'b0, 16'd50, 16'd2,      8'd1, 8'd3,    2'b00, 16'd0, 16'd0, 16'd0};
      vt[1] = '{30, 16'd4,      8'd1, 8'd9,    1'b0, 1'b1, 1'b0, 16'd50, 16'd2,      8'd1, 8'd3,    2'b00, 16'd0, 16'd0, 16'd1};
      vt[2] = '{20, 16'd5,      8'd1, 8'd7,    1'b0, 1'b1, 1'b0, 16'd50, 16'd2,      8'd1, 8'd3,    2'b00, 16'd1, 16'd0, 16'd1};
      vt[3] = '{8,  16'd0,      8'd0, 8'd0,    1'b1, 1'b1, 1'b1, 16'd30, 16'd4,      8'd1, 8'd9,    2'b01, 16'd1, 16'd1, 16'd1};
      vt[4] = '{12, 16'd6,      8'd1, 8'h44,   1'b1, 1'b1, 1'b0, 16'd12, 16'd6,      8'd1, 8'h44,   2'b00, 16'd1, 16'd1, 16'd1};
      vt[5] = '{40, 16'hFFFF,   8'd2, 8'd1,    1'b1, 1'b1, 1'b1, 16'd40, 16'hFFFF,   8'd2, 8'd1,    2'b00, 16'd1, 16'd1, 16'd1};
      vt[6] = '{15, 16'd0,      8'd2, 8'd5,    1'b1, 1'b1, 1'b0, 16'd15, 16'd0,      8'd2, 8'd5,    2'b00, 16'd1, 16'd1, 16'd1};
      vt[7] = '{15, 16'd3,      8'd2, 8'd6,    1'b1, 1'b1, 1'b1, 16'd15, 16'd3,      8'd2, 8'd6,    2'b01, 16'd1, 16'd1, 16'd2};
      vt[8] = '{0,  16'd0,      8'd0, 8'd0,    1'b1, 1'b0, 1'b0, 16'd15, 16'd0,      8'd2, 8'd5,    2'b00, 16'd1, 16'd1, 16'd2};
      vt[9] = '{0,  16'd0,      8'd0, 8'd0,    1'b1, 1'b0, 1'b0, 16'd15, 16'd0,      8'd2, 8'd5,    2'b00, 16'd1, 16'd1, 16'd2};

      ack2 = 1'b0;
      do_reset();
      check_reset_state();
      cnt2 = 0;
      max2 = 0;

      for (int r = 0; r < 10; r++) begin
         if (vt[r].len > 0) run_frame(vt[r].len, vt[r].seg, vt[r].id, vt[r].aux, 1'b0, ev);
         if (r == 0) begin
            chk("valid_before_commit", ev, 0);
            check_writes(50, 1'b0, 50, 16'd2, 8'd1, 8'd3);
            chk("trunc_writes", cnt2, 32);
            chk("trunc_max_addr", max2, 31);
            chk("trunc_len", len2, 50);
            chk("trunc_flags", flags2, 2'b10);
            chk("trunc_valid", valid2, 1);
         end
         if (vt[r].ack) ack_pulse();
         chk($sformatf("row%0d_valid", r), out_valid, vt[r].e_valid);
         chk($sformatf("row%0d_bank", r), out_bank, vt[r].e_bank);
         chk($sformatf("row%0d_len", r), out_len, vt[r].e_len);
         chk($sformatf("row%0d_seg", r), out_seg, vt[r].e_seg);
         chk($sformatf("row%0d_id_aux", r), {out_id, out_aux}, {vt[r].e_id, vt[r].e_aux});
         chk($sformatf("row%0d_flags", r), out_flags, vt[r].e_flags);
         chk($sformatf("row%0d_cnts", r), {ovf_cnt, runt_cnt}, {vt[r].e_ovf, vt[r].e_runt});
         chk($sformatf("row%0d_seqerr", r), seqerr_cnt, vt[r].e_se);
      end

      // Ack of bank 0 in the very cycle that bank 1 commits.
      run_frame(20, 16'd9, 8'd3, 8'd1, 1'b0, ev);
      chk("pre_same_valid", out_valid, 1);
      run_frame(25, 16'd10, 8'd3, 8'd2, 1'b1, ev);
      chk("same_valid", out_valid, 1);
      chk("same_bank", out_bank, 1);
      chk("same_len", out_len, 25);
      chk("same_seg", out_seg, 10);
      ack_pulse();
      chk("same_after_ack_valid", out_valid, 0);
      chk("same_after_ack_bank", out_bank, 0);

      // Reset asserted while byte 20 of a 50-byte frame is on the bus.
      for (int i = 0; i < 50; i++) begin
         raw_en  = 1'b1;
         rawdata = frame_byte(i, 50, 16'd7, 8'd4, 8'd8);
         rst     = (i == 20);
         @(negedge rx_clk);
         if (i == 20) begin
            check_reset_state();
            wq_a.delete();
            wq_d.delete();
         end
      end
      rst = 1'b0;
      raw_en = 1'b0;
      repeat (2) @(negedge rx_clk);
      chk("midrst_no_writes", wq_a.size(), 0);
      chk("midrst_valid", out_valid, 0);
      run_frame(8, 16'd1, 8'd1, 8'd1, 1'b0, ev);
      chk("runt_cnt", runt_cnt, 1);
      chk("runt_valid", out_valid, 0);
      run_frame(50, 16'd100, 8'd5, 8'd6, 1'b0, ev);
      check_writes(50, 1'b0, 50, 16'd100, 8'd5, 8'd6);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_bank", out_bank, 0);
      chk("post_rst_len", out_len, 50);
      chk("post_rst_id", out_id, 5);

      // Randomized frames against a frame-level model.
      do_reset();
      m_full[0] = 0; m_full[1] = 0; m_wr = 0; m_rd = 0; m_vld = 0;
      m_last_seg = 0; m_last_id = 0; m_ovf = 0; m_runt = 0; m_se = 0;
      for (int b = 0; b < 2; b++) begin
         mm_len[b] = 0; mm_seg[b] = 0; mm_id[b] = 0; mm_aux[b] = 0; mm_fl[b] = 0;
      end
      for (int f = 0; f < 60; f++) begin
         case ($urandom % 8)
            0:       rl = int'($urandom_range(10, 1));
            1:       rl = HL;
            2:       rl = HL - 1;
            default: rl = int'($urandom_range(90, 12));
         endcase
         rid = 8'($urandom % 3);
         rav = 8'($urandom);
         rs  = ($urandom % 2 == 0) ? 16'(m_last_seg + 16'd1) : 16'($urandom);
         wf  = m_full[m_wr];
         wb  = m_wr;
         if (rl < HL) begin
            m_runt++;
         end else begin
            rerr = m_vld && (rid == m_last_id) && (rs != 16'(m_last_seg + 16'd1));
            if (rerr) m_se++;
            m_last_seg = rs; m_last_id = rid; m_vld = 1;
            if (wf) m_ovf++;
            else begin
               mm_len[m_wr] = 16'(rl); mm_seg[m_wr] = rs; mm_id[m_wr] = rid;
               mm_aux[m_wr] = rav; mm_fl[m_wr] = {1'b0, rerr};
               m_full[m_wr] = 1; m_wr = ~m_wr;
            end
         end
         run_frame(rl, rs, rid, rav, 1'b0, ev);
         check_writes(rl, wb, wf ? 0 : rl, rs, rid, rav);
         if ($urandom % 2 == 0) begin
            ack_pulse();
            if (m_full[m_rd]) begin
               m_full[m_rd] = 0;
               m_rd = ~m_rd;
            end
         end
         chk("rnd_valid", out_valid, m_full[m_rd]);
         chk("rnd_bank", out_bank, m_rd);
         chk("rnd_len_seg", {out_len, out_seg}, {mm_len[m_rd], mm_seg[m_rd]});
         chk("rnd_id_aux_flags", {out_id, out_aux, out_flags}, {mm_id[m_rd], mm_aux[m_rd], mm_fl[m_rd]});
         chk("rnd_ovf", ovf_cnt, m_ovf);
         chk("rnd_runt", runt_cnt, m_runt);
         chk("rnd_seqerr", seqerr_cnt, m_se);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_frame_sched.md
# rx_frame_sched

Receive-side frame scheduler between `ext_crc` (CRC-stripped byte stream) and a two-bank payload RAM. It delimits frames on `raw_en`, writes bytes into a free bank, extracts segment/id/aux header fields and checks segment continuity per id. Completed banks are handed to the consumer with a valid/ack handshake. Frames that arrive while no bank is free are dropped and counted.

## Interface
- `SEG_OFFSET`, default 5: byte index of segment MSB; LSB at +1, id at +2, aux at +5.
- `BUF_AW`, default 11: bank address width; bank capacity 2^BUF_AW bytes.
- `HDR_LEN`, derived: SEG_OFFSET+6; minimum valid frame length.

Ports:
- `rx_clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `rawdata` in 8: byte from `ext_crc`.
- `raw_en` in 1: byte valid; one frame per contiguous high run.
- `buf_we` out 1: RAM write enable.
- `buf_waddr` out BUF_AW+1: {bank, byte index}.
- `buf_wdata` out 8: RAM write data.
- `out_valid` out 1: read bank holds a committed frame.
- `out_ack` in 1: consumer releases read bank.
- `out_bank` out 1: read bank index.
- `out_len` out 16: frame byte count, saturating.
- `out_seg` out 16, `out_id` out 8, `out_aux` out 8: header fields of read bank.
- `out_flags` out 2: {trunc, seq_err} of read bank.
- `ovf_cnt`, `runt_cnt`, `seqerr_cnt` out 16 each: saturating event counters.

## Operation
- States: GAP, IDLE, RECV, DROP, DONE. Reset enters GAP.
- GAP: wait for `raw_en`=0, then IDLE. This discards any frame in progress at reset.
- IDLE, `raw_en`=1: clear byte index to 0.
  - `full[wr_bank]`=1: go to DROP.
  - Otherwise: go to RECV and write byte 0.
- RECV/DROP, `raw_en`=1: increment the index and `len`, saturating at 0xFFFF.
  - Bytes at indices SEG_OFFSET, +1, +2 and +5 are latched into the pending seg/id/aux.
- RECV write rule: bytes with index < 2^BUF_AW are written to `{wr_bank, idx}`.
  - Later bytes are not written and set trunc.
- RECV/DROP, `raw_en`=0: go to DONE.
- DONE lasts one cycle, then IDLE. Evaluation order:
  1. `len` < HDR_LEN: runt. Increment `runt_cnt`. No commit, no sequence update. Bank stays free.
  2. Sequence check. Skip if `seq_vld`=0.
     - If id == `last_id` and seg != `last_seg`+1 (mod 2^16): set seq_err and increment `seqerr_cnt`.
     - Then `last_id`/`last_seg` ← pending values and `seq_vld` ← 1. This update also happens for DROP frames, so an overflow is not re-reported as a sequence error.
  3. RECV frame: store metadata in bank `wr_bank`, set `full[wr_bank]`, toggle `wr_bank`.
  4. DROP frame: increment `ovf_cnt`.
- Read side:
  - `out_valid` = `full[rd_bank]`. `out_bank` = `rd_bank`. `out_*` show that bank's metadata.
  - `out_ack` while `out_valid`=1: clear `full[rd_bank]`, toggle `rd_bank`.
  - `out_ack` while `out_valid`=0: ignored.
- Commit and ack in the same cycle: both take effect. They always address different banks.
- Counters saturate at 0xFFFF.

## Timing
- Reset values:
  - `buf_we`, `buf_waddr`, `buf_wdata` = 0.
  - `out_valid` = 0, `out_bank` = 0; `out_len`/`out_seg`/`out_id`/`out_aux`/`out_flags` = 0.
  - All counters = 0.
  - `wr_bank` = `rd_bank` = 0, `full` = 00, `seq_vld` = 0.
- Write port is registered. A byte sampled at edge N appears on `buf_we`/`buf_waddr`/`buf_wdata` after edge N.
- Commit latency:
  - Last byte sampled at edge N.
  - `raw_en`=0 sampled at edge N+1 → DONE.
  - Commit at edge N+2. `out_valid` is high after N+2.
- Minimum inter-frame gap: 2 idle cycles (DONE + IDLE). A byte arriving during DONE is a protocol violation; behaviour is not required.
- `out_valid` falls one cycle after the acking edge. It stays high if the other bank is full.

## Structure
- Shared package `rx_frame_pkg`:
  - State enum.
  - Field offsets derived from SEG_OFFSET.
  - Frame metadata struct {len, seg, id, aux, trunc, seq_err}.
  - Flag bit positions.
- Natural sub-module: `rx_seq_check`. It holds `last_id`/`last_seg`/`seq_vld` and compares with a 16-bit wrap increment.
- Bank metadata registers stay in the top level as `meta[2]`.

## Test plan
- 50-byte frame: seg 2, id 1, aux 3. → 50 writes to addresses 0..49 on bank 0; `out_valid` high 2 cycles after last byte; `out_len`=50, `out_seg`=2, `out_id`=1, `out_aux`=3, flags=00.
- Frame seg 2 id 1, then frame seg 4 id 1, no ack. → second frame lands in bank 1 with seq_err=1; `seqerr_cnt`=1; third frame dropped with `ovf_cnt`=1.
- Ack bank 0 in the same cycle that frame 2 commits. → `out_valid` stays 1; `out_bank`=1; `full`=10 binary.
- 8-byte frame. → no commit, `runt_cnt`=1, `out_valid` stays 0; next 50-byte frame uses bank 0.
- `BUF_AW`=5 with a 50-byte frame. → only indices 0..31 written; `out_len`=50; trunc=1.
- Assert `rst` mid-frame at byte 20. → outputs return to reset values; remaining bytes are not written; next frame is received normally into bank 0.
